// File: rtl/inst_queue.sv
// Two-wide in-order instruction queue between fetch/decode and the backend.
// Circular buffer with up to two writes and two reads per cycle, plus a single-cycle flush.

package inst_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } inst_t;
endpackage

// Per-output-slot read lane: index into storage and thermometer valid bit.
module inst_queue_rd_lane #(
    parameter int DEPTH = 8,
    parameter int LANE  = 0,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic [AW-1:0] head,
    input  logic [CW-1:0] count,
    output logic [AW-1:0] idx,
    output logic          valid
);
    assign idx   = head + AW'(LANE);
    assign valid = count > CW'(LANE);
endmodule

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1,
    localparam int NUM_LANES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  inst_t [NUM_LANES-1:0]      fe_inst_i,
    input  logic  [NUM_LANES-1:0]      fe_valid_i,
    output logic                       fe_ready_o,
    output inst_t [NUM_LANES-1:0]      inst_o,
    output logic  [NUM_LANES-1:0]      inst_valid_o,
    input  logic  [1:0]                issue_num_i,
    output logic  [CW-1:0]             count_o
);
    inst_t           mem [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;

    logic            enq_fire;
    logic [1:0]      enq_num;
    logic            wr0_en, wr1_en;
    inst_t           wr0_data;
    logic [AW-1:0]   rd_idx [NUM_LANES];

    // Ready looks only at registered occupancy so it stays off the issue path.
    assign fe_ready_o = count <= CW'(DEPTH - 2);
    assign enq_fire   = fe_ready_o && !flush_i;
    assign enq_num    = enq_fire ? 2'(fe_valid_i[0]) + 2'(fe_valid_i[1]) : 2'd0;

    // Compaction: the oldest valid slot always lands at tail.
    assign wr0_en   = enq_fire && (fe_valid_i != 2'b00);
    assign wr1_en   = enq_fire && (fe_valid_i == 2'b11);
    assign wr0_data = fe_valid_i[0] ? fe_inst_i[0] : fe_inst_i[1];

    always_ff @(posedge clk) begin
        if (wr0_en) mem[tail]            <= wr0_data;
        if (wr1_en) mem[tail + AW'(1)]   <= fe_inst_i[1];
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(issue_num_i);
            tail  <= tail + AW'(enq_num);
            count <= count + CW'(enq_num) - CW'(issue_num_i);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_rd
            inst_queue_rd_lane #(.DEPTH(DEPTH), .LANE(g)) u_lane (
                .head  (head),
                .count (count),
                .idx   (rd_idx[g]),
                .valid (inst_valid_o[g])
            );
            assign inst_o[g] = mem[rd_idx[g]];
        end
    endgenerate

    assign count_o = count;

    // The backend may never retire more than it was shown.
    a_issue_legal: assert property (@(posedge clk) disable iff (rst)
        $countones(inst_valid_o) >= int'(issue_num_i));
endmodule
